prescaler_multi: RTL
====================

# prescaler_multi

Multi-channel fractional clock-enable generator, the parametrised successor to the single-channel prescaler. Each channel produces one-cycle `tick` pulses at an exact average rate Fclk*M/D, with no off-by-one. Each channel runs either continuously or as a counted burst with start/done handshakes, and checks its configuration when it starts. It sits beside the LED sequencers and feeds their step enables. It replaces per-sequencer prescaler instances.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent channels.
- `BITS`, default 32: width of the multiplier and divider.
- `CNT_BITS`, default 16: width of the burst length.

Ports (channel i occupies bit i or slice [i*W +: W]):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `clear_n` in 1: synchronous clear of all channels, active low.
- `enable` in CHANNELS: per-channel enable, level-sensitive.
- `mode` in CHANNELS: 0 = continuous, 1 = burst.
- `start` in CHANNELS: burst start pulse. Ignored in continuous mode.
- `multiplier` in CHANNELS*BITS: M per channel.
- `divider` in CHANNELS*BITS: D per channel.
- `burst_len` in CHANNELS*CNT_BITS: number of ticks per burst.
- `tick` out CHANNELS: registered one-cycle tick.
- `busy` out CHANNELS: channel is in RUN.
- `done` out CHANNELS: one-cycle pulse at burst completion.
- `cfg_err` out CHANNELS: last start attempt was rejected; sticky.

## Operation
- Per-channel FSM with states IDLE and RUN.
- Continuous mode: IDLE→RUN on a cycle where `enable`=1. RUN→IDLE when `enable`=0.
- Burst mode: IDLE→RUN on `start`=1 with `enable`=1. RUN→IDLE after `burst_len` ticks, or when `enable`=0 (abort, no `done`).
- Start attempt: M, D and burst_len are latched into shadow registers. Input changes during RUN have no effect.
- Config check on the start attempt: D==0 or M>D means reject.
  - On reject: stay IDLE, set `cfg_err`, no ticks.
  - `cfg_err` clears on the next accepted start attempt, on `clear_n`=0, or on reset.
- Accumulator `acc` is BITS+1 bits wide, so `acc`+M never overflows. `acc` is zeroed on entry to RUN.
- In RUN, each cycle: `nxt` = `acc` + M.
  - If `nxt` >= D: `acc` ← `nxt` − D and `tick` ← 1.
  - Otherwise: `acc` ← `nxt` and `tick` ← 0.
- Comparison is >=, so the tick rate is exactly M/D of Fclk. Invariant: `acc` < D.
- Burst: the tick counter (CNT_BITS) counts asserted ticks. Completion happens on the cycle `tick` is driven for tick number `burst_len`; `done` is asserted together with that final `tick`, then IDLE.
- `burst_len`=0: accepted start goes directly to IDLE with `done` pulsed next cycle. No ticks, `busy` never asserts.
- `start` while in RUN is ignored. `start` with `enable`=0 is ignored and does not set `cfg_err`.
- `clear_n`=0 (synchronous), all channels: IDLE, `acc`=0, counter=0, all outputs 0. It overrides `start`/`enable` in the same cycle.
- Reset values: all outputs 0, all FSMs IDLE, `acc`=0.

## Timing
- Start attempt at edge E0: `busy`=1 after E0. Accumulation begins at E1.
- First tick is visible after edge E(k), where k = ceil(D/M) counted from E1. Example: M=1, D=4 → `tick` is high in the cycle after E4, then every 4 cycles.
- `tick` is registered. Its latency from the crossing edge is 0 cycles: it is high for the cycle immediately after that edge.
- `enable` falling, sampled at edge E: `busy`=0 and `tick`=0 after E. An in-flight tick is suppressed.
- M==D: `tick` is high every cycle from the cycle after E1 onward.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Structure
- Package `prescaler_pkg`:
  - Constants `MODE_CONT`=0 and `MODE_BURST`=1.
  - State encoding `ST_IDLE` and `ST_RUN`.
- Sub-module `prescaler_channel`: one FSM, accumulator, counter and shadow registers. The top level is a generate loop over CHANNELS plus bus slicing.

## Test plan
- ch0 continuous, M=1, D=4, `enable` held high 20 cycles → ticks at cycles 5, 9, 13, 17 relative to E0; `acc` never reaches 4.
- ch1 continuous, M=3, D=8, 80 cycles → exactly 30 ticks; no two ticks more than 3 cycles apart.
- ch2 burst, M=1, D=2, `burst_len`=5, start pulse → 5 ticks; `done` coincides with the 5th tick; `busy` drops the next cycle; a second start while busy is ignored.
- Config errors: ch3 with D=0, then with M=9, D=8 → `cfg_err`=1 and no ticks/busy; a valid start afterwards clears `cfg_err` and runs.
- Abort/clear: `clear_n` pulsed mid-burst on ch2 while ch0 is continuous → all outputs 0 the next cycle, no `done`; restart yields the full `burst_len`. `rst_n` asserted asynchronously mid-cycle → outputs 0 immediately.
- Burst edge cases: `burst_len`=0 → `done` only, `busy` never high. M=D=7 continuous → tick every cycle.

Source files
------------

// File: rtl/prescaler_pkg.sv
// Shared constants and state encoding for the multi-channel fractional prescaler.
// Latency: n/a (definitions only).
// Backpressure: n/a (no flow-controlled interfaces).
package prescaler_pkg;

  // Per-channel operating mode, as presented on the mode input bit.
  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // Channel FSM encoding. busy is simply "state == ST_RUN".
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/prescaler_channel.sv
// One fractional clock-enable channel: FSM, phase accumulator, tick counter, shadow config.
// Latency: busy after the start edge; tick is registered and high the cycle after the crossing edge.
// Backpressure: none; enable low aborts immediately, start while running is ignored.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear_n               sync active-low clear (overrides everything else)
//   enable, mode, start   channel control (mode: 0 continuous, 1 burst)
//   multiplier, divider   M and D, sampled on a start attempt
//   burst_len             ticks per burst, sampled on a start attempt
//   tick, busy, done      registered tick, RUN indicator, burst-complete pulse
//   cfg_err               sticky: last start attempt had D==0 or M>D
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_n,
  input  logic                enable,
  input  logic                mode,
  input  logic                start,
  input  logic [BITS-1:0]     multiplier,
  input  logic [BITS-1:0]     divider,
  input  logic [CNT_BITS-1:0] burst_len,
  output logic                tick,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  state_t              state, state_n;
  logic [BITS:0]       acc, acc_n;
  logic [BITS:0]       nxt;
  logic [CNT_BITS-1:0] cnt, cnt_n, cnt_inc;
  logic                tick_n, done_n, err_n;
  logic                attempt, cfg_bad, load;

  // Shadow copies so that input changes during RUN have no effect.
  logic [BITS-1:0]     m_sh, d_sh;
  logic [CNT_BITS-1:0] len_sh;
  logic                mode_sh;

  // The accumulator is one bit wider than M/D, so acc + M cannot wrap
  // while the invariant acc < D holds.
  assign nxt     = acc + {1'b0, m_sh};
  assign cnt_inc = cnt + CNT_BITS'(1);

  assign attempt = enable && ((mode == MODE_CONT) || start);
  assign cfg_bad = (divider == '0) || (multiplier > divider);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = cfg_err;
    load    = 1'b0;

    if (!clear_n) begin
      state_n = ST_IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      err_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (attempt) begin
            load = 1'b1;
            if (cfg_bad) begin
              err_n = 1'b1;
            end else begin
              err_n = 1'b0;
              acc_n = '0;
              cnt_n = '0;
              // A zero-length burst completes without ever entering RUN.
              if ((mode == MODE_BURST) && (burst_len == '0)) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_RUN;
              end
            end
          end
        end

        ST_RUN: begin
          // done was registered together with the final tick; the channel
          // spends that cycle still busy and returns to IDLE at this edge.
          if (!enable || done) begin
            state_n = ST_IDLE;
          end else if (nxt >= {1'b0, d_sh}) begin
            acc_n  = nxt - {1'b0, d_sh};
            tick_n = 1'b1;
            if (mode_sh == MODE_BURST) begin
              cnt_n = cnt_inc;
              if (cnt_inc == len_sh) begin
                done_n = 1'b1;
              end
            end
          end else begin
            acc_n = nxt;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      m_sh    <= '0;
      d_sh    <= '0;
      len_sh  <= '0;
      mode_sh <= MODE_CONT;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      tick    <= tick_n;
      done    <= done_n;
      cfg_err <= err_n;
      if (load) begin
        m_sh    <= multiplier;
        d_sh    <= divider;
        len_sh  <= burst_len;
        mode_sh <= mode;
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: rtl/prescaler_multi.sv
// Multi-channel fractional clock-enable generator; each channel ticks at Fclk*M/D on average.
// Latency: tick is registered, high the cycle after the edge where the accumulator crosses D.
// Backpressure: none; channels are independent and free-running once started.
//
// Ports (channel i uses bit i or slice [i*W +: W]):
//   clk, rst_n, clear_n        clock, async active-low reset, sync active-low clear
//   enable, mode, start        per-channel control
//   multiplier, divider        per-channel M and D (BITS each)
//   burst_len                  per-channel burst length (CNT_BITS each)
//   tick, busy, done, cfg_err  per-channel status
module prescaler_multi
  import prescaler_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_n,
  input  logic [CHANNELS-1:0]          enable,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS*BITS-1:0]     multiplier,
  input  logic [CHANNELS*BITS-1:0]     divider,
  input  logic [CHANNELS*CNT_BITS-1:0] burst_len,
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          done,
  output logic [CHANNELS-1:0]          cfg_err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    prescaler_channel #(
      .BITS     (BITS),
      .CNT_BITS (CNT_BITS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_n    (clear_n),
      .enable     (enable[i]),
      .mode       (mode[i]),
      .start      (start[i]),
      .multiplier (multiplier[i*BITS +: BITS]),
      .divider    (divider[i*BITS +: BITS]),
      .burst_len  (burst_len[i*CNT_BITS +: CNT_BITS]),
      .tick       (tick[i]),
      .busy       (busy[i]),
      .done       (done[i]),
      .cfg_err    (cfg_err[i])
    );
  end

endmodule
